// File: rtl/hex_serial_subtractor.sv
// hex_serial_subtractor: bit-serial Diff = A - B - Bin, LSB first, W+1 clocks/op.
// Ports: clk, rst (sync, active-high), start/ready/done handshake,
//   A, B (W-bit operands), Bin (borrow in), Diff (W-bit), Bout (borrow out).
// Optional macro HEX_SUB_OVF_EN adds output Ovf (signed overflow flag).
module hex_serial_subtractor #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Bin,
    output logic         ready,
    output logic         done,
    output logic [W-1:0] Diff,
    output logic         Bout
`ifdef HEX_SUB_OVF_EN
    ,
    output logic         Ovf
`endif
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_opa;
    logic [W-1:0]   r_opb;
    logic           r_brw;
    logic [W-1:0]   r_res;
    logic [CW-1:0]  r_cnt;
    logic           r_ready;
    logic           r_done;
    logic [W-1:0]   r_diff;
    logic           r_bout;
`ifdef HEX_SUB_OVF_EN
    // Operand sign bits, kept because r_opa/r_opb are shifted away.
    logic           r_amsb;
    logic           r_bmsb;
    logic           r_ovf;
`endif

    logic           w_d;
    logic           w_brw;
    logic [W-1:0]   w_res;
    logic           w_last;

    // Full-subtractor cell for the current bit.
    assign w_d    = r_opa[0] ^ r_opb[0] ^ r_brw;
    assign w_brw  = (~r_opa[0] & r_opb[0])
                  | (~(r_opa[0] ^ r_opb[0]) & r_brw);
    assign w_res  = {w_d, r_res[W-1:1]};
    assign w_last = (r_cnt == CW'(W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_opa   <= '0;
            r_opb   <= '0;
            r_brw   <= 1'b0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
`ifdef HEX_SUB_OVF_EN
            r_amsb  <= 1'b0;
            r_bmsb  <= 1'b0;
            r_ovf   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                // DONE accepts a start exactly like IDLE (back-to-back).
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_opa   <= A;
                        r_opb   <= B;
                        r_brw   <= Bin;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_state <= S_SHIFT;
`ifdef HEX_SUB_OVF_EN
                        r_amsb  <= A[W-1];
                        r_bmsb  <= B[W-1];
`endif
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    r_res <= w_res;
                    r_opa <= r_opa >> 1;
                    r_opb <= r_opb >> 1;
                    r_brw <= w_brw;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_ready <= 1'b1;
                        r_done  <= 1'b1;
                        r_diff  <= w_res;
                        r_bout  <= w_brw;
`ifdef HEX_SUB_OVF_EN
                        // w_d is the result MSB on the last bit.
                        r_ovf   <= (r_amsb ^ r_bmsb) & (w_d ^ r_amsb);
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready = r_ready;
    assign done  = r_done;
    assign Diff  = r_diff;
    assign Bout  = r_bout;
`ifdef HEX_SUB_OVF_EN
    assign Ovf   = r_ovf;
`endif

endmodule
